dma_copy_engine: RTL and testbench
==================================

# dma_copy_engine

Single-channel word-granular memory-to-memory copy engine that acts as one DMA master in front of `dma_gateway`. Software programs a source, a destination and a word count, then pulses start. The engine sequences alternating read and write transactions over the data-memory request/done handshake and reports completion, abort or fault. It owns no memory; every access passes through the gateway and firewall, which may refuse it via `m_fault`.

## Interface
- LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W − 1 words.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_abort  in  1  level; stops the transfer at the next transaction boundary.
- cfg_src  in  32  source byte address; captured on start.
- cfg_dst  in  32  destination byte address; captured on start.
- cfg_len  in  LEN_W  number of 32-bit words; captured on start.
- m_req  out  1  bus request.
- m_we  out  1  1 = write.
- m_be  out  4  byte enables.
- m_addr  out  32  bus address.
- m_wdata  out  32  write data.
- m_rdata  in  32  read data; valid when m_done = 1.
- m_done  in  1  one-cycle transaction completion.
- m_fault  in  1  qualified by m_done; the access was refused.
- busy  out  1  transfer in progress (any state other than IDLE).
- done_pulse  out  1  one-cycle pulse at the end of a transfer (success, abort or error).
- err  out  1  sticky; cleared by the next accepted start.
- err_code  out  2  0 = none, 1 = read fault, 2 = write fault, 3 = misaligned src/dst.
- fault_addr  out  32  address of the faulting access, or the misaligned start address.
- words_left  out  LEN_W  words remaining.

## Operation
- States:
  - IDLE: waits for start.
  - RD: m_req=1, m_we=0, m_addr=src_ptr, m_be=4'h0.
  - GAP_W: m_req=0 for one cycle.
  - WR: m_req=1, m_we=1, m_addr=dst_ptr, m_be=4'hF, m_wdata=buf.
  - GAP_R: m_req=0 for one cycle.
  - FIN: one cycle; done_pulse=1; returns to IDLE.
- IDLE + cfg_start captures src, dst and len, clears err/err_code/fault_addr, then:
  - if cfg_src[1:0] ≠ 0 → FIN with err=1, code 3, fault_addr=cfg_src;
  - else if cfg_dst[1:0] ≠ 0 → FIN with err=1, code 3, fault_addr=cfg_dst;
  - else if cfg_len = 0 → FIN with no bus traffic;
  - else → RD.
- RD + m_done:
  - m_fault=1 → FIN, err=1, code 1, fault_addr=src_ptr;
  - otherwise buf ← m_rdata, then → GAP_W.
- WR + m_done:
  - m_fault=1 → FIN, err=1, code 2, fault_addr=dst_ptr;
  - otherwise src_ptr += 4, dst_ptr += 4 (mod 2^32), words_left −= 1;
  - then → FIN if words_left was 1 or cfg_abort=1, else → GAP_R.
- GAP_R → RD and GAP_W → WR unconditionally. Exception: in GAP_R with cfg_abort=1, go → FIN.
- m_req, m_we, m_addr, m_be and m_wdata are held stable from request assertion until m_done. Once raised, m_req is never dropped before m_done, because the gateway holds the grant until completion.
- cfg_abort is never honoured inside RD or WR. An abort during RD still completes that read and its write.
- cfg_start outside IDLE is ignored. cfg_* changes after start have no effect.
- On a non-address-wrap boundary the pointers simply wrap at 2^32; no error is raised.

## Timing
- Reset (rst=1 at a clk edge), including mid-transfer: state IDLE, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, busy=0, done_pulse=0, err=0, err_code=0, fault_addr=0, words_left=0, buf=0.
- Bus outputs are registered (Moore). m_req rises the cycle after the start pulse is sampled.
- m_done in cycle t with RD/WR active: the state changes at edge t+1, so m_req is low in cycle t+1. This gap lets the gateway return to G_IDLE and re-arbitrate.
- Per word, minimum cycles = read latency + write latency + 2. With 1-cycle-done memory and immediate grant, that is 6 cycles/word: RD 2, GAP_W 1, WR 2, GAP_R 1.
- busy rises the cycle after start and falls the cycle after FIN.
- done_pulse is coincident with FIN. err, err_code and fault_addr are valid in the FIN cycle and thereafter.
- m_done or m_fault arriving outside RD/WR is ignored.

## Test plan
- Copy src=0x1000, dst=0x2000, len=3 with a 1-cycle-latency memory model → reads of 0x1000/4/8 and writes of 0x2000/4/8 interleaved R,W,R,W,R,W. The destination holds the source data, words_left ends at 0, done_pulse fires once, err=0, and m_req drops for exactly one cycle between transactions.
- Read fault: src=0x1000, len=4, with m_fault asserted on the read of 0x1008 → exactly two writes occur, then err=1, err_code=1, fault_addr=0x1008, words_left=2, done_pulse.
- Error and zero-length start: cfg_src=0x1002 → no bus request, err_code=3, fault_addr=0x1002, done_pulse the cycle after start. len=0 with aligned addresses → done_pulse, no bus request, err=0.
- Abort: assert cfg_abort while RD of word 1 (len=5) is pending, with a 4-cycle memory latency → m_req stays high until m_done, the write of word 1 completes, then FIN. words_left=3, err=0.
- Pointer wrap and start handling: src=0xFFFF_FFFC, len=2 → second read at 0x0000_0000. A cfg_start issued while busy is ignored.
- Reset mid-transfer: rst during WR → all outputs return to reset values next cycle. A new start afterwards runs a clean transfer.

Source files
------------

// File: rtl/dma_copy_engine.sv
// Single-channel word copy engine: alternating read/write bus transactions
// with a one-cycle request gap so the gateway can re-arbitrate.
module dma_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             m_req,
  output logic             m_we,
  output logic [3:0]       m_be,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_done,
  input  logic             m_fault,
  output logic             busy,
  output logic             done_pulse,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [31:0]      fault_addr,
  output logic [LEN_W-1:0] words_left
);

  typedef enum logic [2:0] {
    IDLE, RD, GAP_W, WR, GAP_R, FIN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] src_ptr, dst_ptr, data_buf;
  logic        last_word;
  logic        misaligned;

  assign last_word  = (words_left == LEN_W'(1));
  assign misaligned = (cfg_src[1:0] != 2'b00)
                    || (cfg_dst[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_be       = 4'h0;
    m_addr     = 32'h0;
    m_wdata    = 32'h0;
    busy       = 1'b1;
    done_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          if (misaligned || cfg_len == '0) state_nxt = FIN;
          else                             state_nxt = RD;
        end
      end
      RD: begin
        m_req  = 1'b1;
        m_addr = src_ptr;
        if (m_done) state_nxt = m_fault ? FIN : GAP_W;
      end
      GAP_W: state_nxt = WR;
      WR: begin
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_be    = 4'hF;
        m_addr  = dst_ptr;
        m_wdata = data_buf;
        if (m_done) begin
          if (m_fault || last_word || cfg_abort) state_nxt = FIN;
          else                                   state_nxt = GAP_R;
        end
      end
      GAP_R: state_nxt = cfg_abort ? FIN : RD;
      FIN: begin
        done_pulse = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr    <= 32'h0;
      dst_ptr    <= 32'h0;
      data_buf   <= 32'h0;
      words_left <= '0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      fault_addr <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (cfg_start) begin
          src_ptr    <= cfg_src;
          dst_ptr    <= cfg_dst;
          words_left <= cfg_len;
          err        <= 1'b0;
          err_code   <= 2'd0;
          fault_addr <= 32'h0;
          if (cfg_src[1:0] != 2'b00) begin
            err        <= 1'b1;
            err_code   <= 2'd3;
            fault_addr <= cfg_src;
          end else if (cfg_dst[1:0] != 2'b00) begin
            err        <= 1'b1;
            err_code   <= 2'd3;
            fault_addr <= cfg_dst;
          end
        end
        RD: if (m_done) begin
          if (m_fault) begin
            err        <= 1'b1;
            err_code   <= 2'd1;
            fault_addr <= src_ptr;
          end else begin
            data_buf <= m_rdata;
          end
        end
        WR: if (m_done) begin
          if (m_fault) begin
            err        <= 1'b1;
            err_code   <= 2'd2;
            fault_addr <= dst_ptr;
          end else begin
            src_ptr    <= src_ptr + 32'd4;
            dst_ptr    <= dst_ptr + 32'd4;
            words_left <= words_left - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a latency-configurable memory
// responder feeds bus and completion monitors against expected queues.
module tb_dma_copy_engine;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_start = 1'b0;
  logic             cfg_abort = 1'b0;
  logic [31:0]      cfg_src = '0;
  logic [31:0]      cfg_dst = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             m_req, m_we;
  logic [3:0]       m_be;
  logic [31:0]      m_addr, m_wdata;
  logic [31:0]      m_rdata = '0;
  logic             m_done = 1'b0;
  logic             m_fault = 1'b0;
  logic             busy, done_pulse, err;
  logic [1:0]       err_code;
  logic [31:0]      fault_addr;
  logic [LEN_W-1:0] words_left;

  always #5 clk = ~clk;

  dma_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .m_req(m_req), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_fault(m_fault),
    .busy(busy), .done_pulse(done_pulse), .err(err),
    .err_code(err_code), .fault_addr(fault_addr),
    .words_left(words_left)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic        err;
    logic [1:0]  code;
    logic [31:0] fa;
    logic [15:0] wl;
  } cpl_t;

  txn_t exp_q[$];
  cpl_t cpl_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat = 1;
  logic f_en = 1'b0;
  logic f_we = 1'b0;
  logic [31:0] f_addr = '0;
  int   cnt = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  txn_t cap;
  event txn_ev;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                           input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, s + 32'(4*i), 32'h0});
      exp_q.push_back('{1'b1, d + 32'(4*i), init_val(s + 32'(4*i))});
    end
  endtask

  task automatic push_cpl(input logic e, input logic [1:0] c,
                          input logic [31:0] fa, input logic [15:0] wl);
    cpl_q.push_back('{e, c, fa, wl});
  endtask

  // returns at the negedge of the first busy cycle
  task automatic start(input logic [31:0] s, input logic [31:0] d,
                       input logic [LEN_W-1:0] n);
    @(negedge clk);
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = n;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_pulse) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: got timeout expected done_pulse");
  endtask

  task automatic wait_bus(input logic we, input logic [31:0] a,
                          input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_req && m_we == we && m_addr == a) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_bus: got timeout expected request at %h", a);
  endtask

  // memory responder
  always @(negedge clk) begin
    if (rst) begin
      m_done  = 1'b0;
      m_fault = 1'b0;
      cnt     = 0;
    end else if (m_done) begin
      m_done  = 1'b0;
      m_fault = 1'b0;
      cnt     = 0;
    end else if (m_req) begin
      cnt++;
      if (cnt > lat) begin
        m_done  = 1'b1;
        m_fault = f_en && (m_addr == f_addr) && (m_we == f_we);
        if (!m_we)        m_rdata = mem_rd(m_addr);
        else if (!m_fault) mem[m_addr] = m_wdata;
        cap = '{m_we, m_addr, m_we ? m_wdata : 32'h0};
        -> txn_ev;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(txn_ev) begin
    txn_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bus_unexpected: got we=%0b addr=%h expected none",
               cap.we, cap.addr);
    end else begin
      e = exp_q.pop_front();
      chk("bus_txn", cap, e);
    end
  end

  always @(negedge clk) begin
    cpl_t e;
    if (busy) busy_cnt++;
    if (!rst && done_pulse) begin
      done_cnt++;
      if (cpl_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cpl_unexpected: got done_pulse expected none");
      end else begin
        e = cpl_q.pop_front();
        chk("completion", {err, err_code, fault_addr, words_left}, e);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bus", {m_req, m_we, m_be, m_addr, m_wdata}, 0);
    chk("reset_status",
        {busy, done_pulse, err, err_code, fault_addr, words_left}, 0);
    rst = 1'b0;

    // plain 3-word copy, 1-cycle memory
    lat = 1;
    push_copy(32'h1000, 32'h2000, 3);
    push_cpl(1'b0, 2'd0, 32'h0, 16'd0);
    busy_cnt = 0;
    done_cnt = 0;
    start(32'h1000, 32'h2000, 3);
    wait_done(100);
    @(negedge clk);
    chk("copy_busy_cycles", busy_cnt, 18);
    chk("copy_done_once", done_cnt, 1);
    for (int i = 0; i < 3; i++)
      chk("copy_dest", mem_rd(32'h2000 + 32'(4*i)),
          init_val(32'h1000 + 32'(4*i)));

    // read fault on third word
    f_en   = 1'b1;
    f_we   = 1'b0;
    f_addr = 32'h1008;
    push_copy(32'h1000, 32'h2000, 2);
    exp_q.push_back('{1'b0, 32'h1008, 32'h0});
    push_cpl(1'b1, 2'd1, 32'h1008, 16'd2);
    start(32'h1000, 32'h2000, 4);
    wait_done(100);
    @(negedge clk);
    chk("fault_sticky", {busy, err, err_code}, 4'b0_1_01);
    f_en = 1'b0;

    // misaligned source / destination, zero length
    push_cpl(1'b1, 2'd3, 32'h1002, 16'd2);
    start(32'h1002, 32'h2000, 2);
    chk("mis_src_pulse", {done_pulse, m_req}, 2'b10);
    push_cpl(1'b1, 2'd3, 32'h2003, 16'd1);
    start(32'h1000, 32'h2003, 1);
    chk("mis_dst_pulse", {done_pulse, m_req}, 2'b10);
    push_cpl(1'b0, 2'd0, 32'h0, 16'd0);
    start(32'h1000, 32'h2000, 0);
    chk("zero_len_pulse", {done_pulse, m_req, err}, 3'b100);
    @(negedge clk);

    // abort during second read, 4-cycle memory
    lat = 4;
    push_copy(32'h1000, 32'h2000, 2);
    push_cpl(1'b0, 2'd0, 32'h0, 16'd3);
    start(32'h1000, 32'h2000, 5);
    wait_bus(1'b0, 32'h1004, 100);
    cfg_abort = 1'b1;
    @(negedge clk);
    chk("abort_req_held", {m_req, m_addr}, {1'b1, 32'h1004});
    wait_done(100);
    cfg_abort = 1'b0;
    @(negedge clk);

    // pointer wrap; second start while busy is ignored
    lat = 1;
    push_copy(32'hFFFF_FFFC, 32'h3000, 2);
    push_cpl(1'b0, 2'd0, 32'h0, 16'd0);
    start(32'hFFFF_FFFC, 32'h3000, 2);
    repeat (2) @(negedge clk);
    cfg_src   = 32'h5000;
    cfg_dst   = 32'h6000;
    cfg_len   = 7;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done(100);
    @(negedge clk);
    chk("wrap_dest", mem_rd(32'h3004), init_val(32'h0));

    // reset in the middle of a write
    exp_q.push_back('{1'b0, 32'h1000, 32'h0});
    start(32'h1000, 32'h2000, 3);
    wait_bus(1'b1, 32'h2000, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bus", {m_req, m_we, m_be, m_addr, m_wdata}, 0);
    chk("midrst_status",
        {busy, done_pulse, err, err_code, fault_addr, words_left}, 0);
    rst = 1'b0;
    exp_q.delete();
    push_copy(32'h1100, 32'h2100, 1);
    push_cpl(1'b0, 2'd0, 32'h0, 16'd0);
    start(32'h1100, 32'h2100, 1);
    wait_done(100);
    @(negedge clk);
    chk("post_rst_dest", mem_rd(32'h2100), init_val(32'h1100));

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", exp_q.size(), 0);
    chk("cpl_queue_drained", cpl_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
